// File: rtl/alu_seq.sv
// Multi-cycle ALU sequencer: single-pass arithmetic/logic ops plus iterated shifts.
// Optional macro ALU_SEQ_B2B_EN lets a new request be accepted during the response handshake.
package defs_pkg;
  typedef enum logic [2:0] {
    OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR  = 3'd3,
    OP_XOR = 3'd4, OP_SLL = 3'd5, OP_SRL = 3'd6, OP_SRA = 3'd7
  } alu_opcode_t;

  typedef struct packed {
    logic carry;
    logic overflow;
    logic zero;
    logic negative;
  } alu_flags_t;
endpackage

module alu
  import defs_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  alu_opcode_t      op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic [WIDTH-1:0] out,
  output alu_flags_t       flags
);
  logic [WIDTH:0] ext;

  // SUB carry is a borrow; shifts move by exactly one bit.
  always_comb begin
    ext            = '0;
    out            = '0;
    flags.carry    = 1'b0;
    flags.overflow = 1'b0;
    case (op)
      OP_ADD: begin
        ext            = {1'b0, in1} + {1'b0, in2};
        out            = ext[WIDTH-1:0];
        flags.carry    = ext[WIDTH];
        flags.overflow = (in1[WIDTH-1] == in2[WIDTH-1]) && (out[WIDTH-1] != in1[WIDTH-1]);
      end
      OP_SUB: begin
        ext            = {1'b0, in1} - {1'b0, in2};
        out            = ext[WIDTH-1:0];
        flags.carry    = ext[WIDTH];
        flags.overflow = (in1[WIDTH-1] != in2[WIDTH-1]) && (out[WIDTH-1] != in1[WIDTH-1]);
      end
      OP_AND: out = in1 & in2;
      OP_OR:  out = in1 | in2;
      OP_XOR: out = in1 ^ in2;
      OP_SLL: out = {in1[WIDTH-2:0], 1'b0};
      OP_SRL: out = {1'b0, in1[WIDTH-1:1]};
      OP_SRA: out = {in1[WIDTH-1], in1[WIDTH-1:1]};
      default: out = '0;
    endcase
    flags.zero     = (out == '0);
    flags.negative = out[WIDTH-1];
  end
endmodule

module alu_seq
  import defs_pkg::*;
#(
  parameter  int WIDTH   = 8,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  alu_opcode_t        req_op,
  input  logic [WIDTH-1:0]   req_a,
  input  logic [WIDTH-1:0]   req_b,
  input  logic [SHAMT_W-1:0] req_shamt,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [WIDTH-1:0]   rsp_data,
  output alu_flags_t         rsp_flags,
  output logic               busy
);
  typedef enum logic [1:0] {IDLE, EXEC, SHIFT, RESP} state_t;

  state_t             state;
  alu_opcode_t        op_q;
  logic [WIDTH-1:0]   a_q, b_q, acc;
  logic [SHAMT_W-1:0] cnt;
  logic [WIDTH-1:0]   alu_in1, alu_in2, alu_out;
  alu_flags_t         alu_fl;
  logic               can_accept, accept, req_shift;

`ifdef ALU_SEQ_B2B_EN
  assign can_accept = (state == IDLE) || ((state == RESP) && rsp_ready);
`else
  assign can_accept = (state == IDLE);
`endif
  assign req_ready = can_accept && !rst;
  assign accept    = req_valid && req_ready;
  assign busy      = (state == EXEC) || (state == SHIFT);
  assign req_shift = (req_op == OP_SLL) || (req_op == OP_SRL) || (req_op == OP_SRA);

  // SHIFT iterates on the accumulator; EXEC works on the latched operands.
  assign alu_in1 = (state == SHIFT) ? acc : a_q;
  assign alu_in2 = (state == SHIFT) ? '0  : b_q;

  alu #(.WIDTH(WIDTH)) u_alu (
    .op    (op_q),
    .in1   (alu_in1),
    .in2   (alu_in2),
    .out   (alu_out),
    .flags (alu_fl)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_flags <= '0;
      acc       <= '0;
      cnt       <= '0;
      op_q      <= OP_ADD;
      a_q       <= '0;
      b_q       <= '0;
    end else begin
      case (state)
        EXEC: begin
          rsp_data  <= alu_out;
          rsp_flags <= alu_fl;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        SHIFT: begin
          acc <= alu_out;
          cnt <= cnt - 1'b1;
          if (cnt == SHAMT_W'(1)) begin
            rsp_data  <= alu_out;
            rsp_flags <= alu_fl;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: ;
      endcase
      // A new request overrides the retire path so B2B decode needs no IDLE bubble.
      if (accept) begin
        op_q <= req_op;
        a_q  <= req_a;
        b_q  <= req_b;
        if (req_shift && (req_shamt == '0)) begin
          rsp_data           <= req_a;
          rsp_flags          <= '0;
          rsp_flags.zero     <= (req_a == '0);
          rsp_flags.negative <= req_a[WIDTH-1];
          rsp_valid          <= 1'b1;
          state              <= RESP;
        end else if (req_shift) begin
          acc   <= req_a;
          cnt   <= req_shamt;
          state <= SHIFT;
        end else begin
          state <= EXEC;
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq; expected values are hand-computed constants.
module tb_alu_seq;
  import defs_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  alu_opcode_t req_op = OP_ADD;
  logic [7:0]  req_a = '0, req_b = '0;
  logic [2:0]  req_shamt = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [7:0]  rsp_data;
  alu_flags_t  rsp_flags;
  logic        busy;

  int n_vec = 0;
  int n_bad = 0;

  alu_seq #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .req_shamt(req_shamt),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_flags(rsp_flags), .busy(busy)
  );

  always #5 clk = ~clk;

  // Issues one request and returns edges from accept to rsp_valid and busy cycles seen.
  task automatic issue(input alu_opcode_t op, input logic [7:0] a, input logic [7:0] b,
                       input logic [2:0] sh, output int lat, output int busy_cnt);
    int guard = 0;
    @(negedge clk);
    req_op = op; req_a = a; req_b = b; req_shamt = sh; req_valid = 1'b1;
    while (!req_ready && guard < 20) begin @(negedge clk); guard++; end
    @(posedge clk);
    lat = 1; busy_cnt = 0;
    @(negedge clk);
    req_valid = 1'b0;
    req_a = 8'h5A; req_b = 8'hA5; req_shamt = 3'd2;
    if (busy) busy_cnt++;
    while (!rsp_valid && lat < 40) begin
      @(posedge clk); lat++;
      @(negedge clk);
      if (busy) busy_cnt++;
    end
    if (guard >= 20) lat = -1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #12;
    n_vec++;
    if ({rsp_valid, busy, req_ready} !== 3'b000) begin
      n_bad++; $display("FAIL reset_ctl: got %b expected 000", {rsp_valid, busy, req_ready});
    end
    n_vec++;
    if ({rsp_data, rsp_flags} !== 12'h000) begin
      n_bad++; $display("FAIL reset_data: got %h expected 000", {rsp_data, rsp_flags});
    end
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if (req_ready !== 1'b1) begin
      n_bad++; $display("FAIL reset_release_ready: got %b expected 1", req_ready);
    end
  endtask

  task automatic test_add;
    int lat, bc;
    rsp_ready = 1'b1;
    issue(OP_ADD, 8'hF0, 8'h20, 3'd0, lat, bc);
    n_vec++;
    if (lat !== 2) begin n_bad++; $display("FAIL add_latency: got %0d expected 2", lat); end
    n_vec++;
    if (rsp_data !== 8'h10 || rsp_flags !== 4'b1000) begin
      n_bad++; $display("FAIL add_result: got %h/%b expected 10/1000", rsp_data, rsp_flags);
    end
    @(posedge clk); @(negedge clk);
    n_vec++;
    if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL add_valid_width: got %b expected 0", rsp_valid); end
  endtask

  task automatic test_sub;
    int lat, bc;
    issue(OP_SUB, 8'h03, 8'h05, 3'd0, lat, bc);
    n_vec++;
    if (rsp_data !== 8'hFE || rsp_flags !== 4'b1001) begin
      n_bad++; $display("FAIL sub_neg: got %h/%b expected fe/1001", rsp_data, rsp_flags);
    end
    issue(OP_SUB, 8'h05, 8'h05, 3'd0, lat, bc);
    n_vec++;
    if (rsp_data !== 8'h00 || rsp_flags !== 4'b0010) begin
      n_bad++; $display("FAIL sub_zero: got %h/%b expected 00/0010", rsp_data, rsp_flags);
    end
  endtask

  task automatic test_shift;
    int lat, bc;
    issue(OP_SRA, 8'h80, 8'h00, 3'd3, lat, bc);
    n_vec++;
    if (lat !== 4 || bc !== 3) begin
      n_bad++; $display("FAIL sra_timing: got lat=%0d busy=%0d expected lat=4 busy=3", lat, bc);
    end
    n_vec++;
    if (rsp_data !== 8'hF0 || rsp_flags !== 4'b0001) begin
      n_bad++; $display("FAIL sra_result: got %h/%b expected f0/0001", rsp_data, rsp_flags);
    end
    issue(OP_SRL, 8'h80, 8'h00, 3'd7, lat, bc);
    n_vec++;
    if (rsp_data !== 8'h01 || rsp_flags !== 4'b0000 || lat !== 8) begin
      n_bad++; $display("FAIL srl7: got %h/%b lat=%0d expected 01/0000 lat=8", rsp_data, rsp_flags, lat);
    end
    issue(OP_SLL, 8'h00, 8'h00, 3'd0, lat, bc);
    n_vec++;
    if (lat !== 1 || bc !== 0) begin
      n_bad++; $display("FAIL sll0_timing: got lat=%0d busy=%0d expected lat=1 busy=0", lat, bc);
    end
    n_vec++;
    if (rsp_data !== 8'h00 || rsp_flags !== 4'b0010) begin
      n_bad++; $display("FAIL sll0_result: got %h/%b expected 00/0010", rsp_data, rsp_flags);
    end
    issue(OP_SLL, 8'h81, 8'h00, 3'd1, lat, bc);
    n_vec++;
    if (rsp_data !== 8'h02 || rsp_flags !== 4'b0000) begin
      n_bad++; $display("FAIL sll1_lost_bit: got %h/%b expected 02/0000", rsp_data, rsp_flags);
    end
    @(posedge clk);
  endtask

  task automatic test_back_to_back;
    int lat, bc, guard;
    @(negedge clk);
    rsp_ready = 1'b0;
    issue(OP_AND, 8'hCC, 8'hAA, 3'd0, lat, bc);
    req_op = OP_XOR; req_a = 8'h0F; req_b = 8'hF0; req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_vec++;
      if (rsp_valid !== 1'b1 || rsp_data !== 8'h88 || rsp_flags !== 4'b0001 || req_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL bp_hold[%0d]: got v=%b d=%h f=%b rdy=%b expected 1/88/0001/0",
                 i, rsp_valid, rsp_data, rsp_flags, req_ready);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1;
    n_vec++;
`ifdef ALU_SEQ_B2B_EN
    if (req_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready_at_hs: got %b expected 1", req_ready); end
    @(negedge clk);
`else
    if (req_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_ready_at_hs: got %b expected 0", req_ready); end
    @(negedge clk);
    n_vec++;
    if (req_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready_after_hs: got %b expected 1", req_ready); end
    @(negedge clk);
`endif
    req_valid = 1'b0;
    guard = 0;
    while (!rsp_valid && guard < 10) begin @(negedge clk); guard++; end
    n_vec++;
    if (rsp_valid !== 1'b1 || rsp_data !== 8'hFF || rsp_flags !== 4'b0001) begin
      n_bad++; $display("FAIL b2b_second: got v=%b %h/%b expected 1 ff/0001", rsp_valid, rsp_data, rsp_flags);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int lat, bc;
    @(negedge clk);
    req_op = OP_SLL; req_a = 8'h01; req_shamt = 3'd7; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk); req_valid = 1'b0;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_vec++;
    if ({rsp_valid, busy, req_ready, rsp_data, rsp_flags} !== 15'h0) begin
      n_bad++; $display("FAIL rst_mid_outputs: got v=%b b=%b r=%b %h/%b expected all 0",
                        rsp_valid, busy, req_ready, rsp_data, rsp_flags);
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_vec++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
        n_bad++; $display("FAIL rst_mid_after[%0d]: got v=%b r=%b expected 0/1", i, rsp_valid, req_ready);
      end
    end
    issue(OP_ADD, 8'h01, 8'h01, 3'd0, lat, bc);
    n_vec++;
    if (rsp_data !== 8'h02 || rsp_flags !== 4'b0000 || lat !== 2) begin
      n_bad++; $display("FAIL rst_mid_add: got %h/%b lat=%0d expected 02/0000 lat=2", rsp_data, rsp_flags, lat);
    end
  endtask

  initial begin
    test_reset;
    test_add;
    test_sub;
    test_shift;
    test_back_to_back;
    test_reset_mid;
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Multi-cycle sequencer wrapped around one internal `alu` instance (WIDTH-bit, opcodes `alu_opcode_t`, flags `alu_flags_t` from `defs_pkg`).
- Accepts one operation request at a time through a valid/ready handshake.
- Runs single-cycle ops (ADD/SUB/AND/OR/XOR) in one ALU pass.
- Runs arbitrary-distance shifts (SLL/SRL/SRA by `req_shamt`) by iterating the ALU's 1-bit shift.
- Returns the result and flags through a valid/ready response port. Sits between the decode/issue logic and the register writeback.

Parameters:
- `WIDTH`, 8: data width, passed to `alu`.
- `SHAMT_W`, `$clog2(WIDTH)`: shift-amount width (localparam, derived).

Ports:
- `clk`  input  1  clock, rising edge
- `rst`  input  1  asynchronous, active-high reset
- `req_valid`  input  1  request present
- `req_ready`  output  1  block can accept a request
- `req_op`  input  `alu_opcode_t`  operation
- `req_a`  input  WIDTH  operand 1 / shift source
- `req_b`  input  WIDTH  operand 2 (ignored for shifts)
- `req_shamt`  input  SHAMT_W  shift distance (ignored for non-shifts)
- `rsp_valid`  output  1  result present
- `rsp_ready`  input  1  consumer accepts result
- `rsp_data`  output  WIDTH  result
- `rsp_flags`  output  `alu_flags_t`  carry/overflow/zero/negative of result
- `busy`  output  1  high in EXEC or SHIFT

Behaviour:
- Reset (async, active-high):
  - state=IDLE.
  - `rsp_valid`=0, `rsp_data`=0, `rsp_flags`=0, `busy`=0.
  - Internal acc, cnt and latched operands = 0.
  - `req_ready`=0 while `rst` is high.
- States: IDLE, EXEC, SHIFT, RESP. `req_ready` = (state==IDLE) && !rst.
- IDLE: on `req_valid`&&`req_ready`, latch op, a, b, shamt. Then:
  - Shift op with shamt==0: `rsp_data`<=a; zero=(a==0); negative=a[WIDTH-1]; carry=overflow=0 → RESP. Latency 1 cycle.
  - Shift op with shamt>0: acc<=a, cnt<=shamt → SHIFT.
  - Any other opcode: → EXEC.
- EXEC:
  - ALU in1=latched a, in2=latched b, op=latched op.
  - Capture ALU out/flags into `rsp_data`/`rsp_flags` → RESP.
  - `rsp_valid` rises 2 cycles after the accept edge.
- SHIFT:
  - ALU in1=acc, op=latched op, in2=0.
  - Each cycle: acc<=out, cnt<=cnt-1.
  - When cnt==1: capture out/flags into `rsp_data`/`rsp_flags` → RESP.
  - `rsp_valid` rises shamt+1 cycles after accept.
  - Shift flags: carry=overflow=0 (as produced by ALU); zero/negative reflect the final value.
- RESP:
  - `rsp_valid`=1. `rsp_data`/`rsp_flags` held stable until `rsp_ready`.
  - On `rsp_ready`: `rsp_valid`<=0 → IDLE.
  - `req_valid` ignored (`req_ready`=0).
- `busy`=1 in EXEC or SHIFT only.
- `rsp_data`/`rsp_flags` keep their last value after the handshake. The bench checks them only while `rsp_valid`=1.
- Maximum shamt = WIDTH-1. Shifting acc is modulo WIDTH (bits shifted out are lost).
- Reset mid-operation: abort immediately, no response emitted; returns to IDLE.
- Request inputs are sampled only at the accept edge; later changes to them have no effect.

Optional Feature:
- Macro: `ALU_SEQ_B2B_EN`.
- Defined:
  - In RESP, `req_ready` = `rsp_ready` && !rst.
  - A response handshake and a request accept in the same cycle retire the response and decode the new request as from IDLE, in one edge (no IDLE bubble).
  - Back-to-back single-cycle ops sustain one result per 2 cycles.
- Undefined: RESP always returns to IDLE; `req_ready`=0 in RESP.

Test Plan:
- ADD a=0xF0 b=0x20, `rsp_ready`=1 → `rsp_data`=0x10, carry=1, overflow=0, zero=0, negative=0; `rsp_valid` 2 cycles after accept, high 1 cycle.
- SUB a=0x03 b=0x05 → 0xFE, carry=1, negative=1, zero=0. Then SUB 0x05-0x05 → 0x00, zero=1, carry=0.
- SRA a=0x80 shamt=3 → 0xF0, negative=1; `busy` high exactly 3 cycles; `rsp_valid` 4 cycles after accept. SRL a=0x80 shamt=7 → 0x01.
- SLL a=0x00 shamt=0 → 0x00, zero=1, carry=0; `rsp_valid` 1 cycle after accept, `busy` never high.
- Backpressure:
  - AND 0xCC,0xAA with `rsp_ready`=0 for 5 cycles, while `req_valid`=1 with a different op → `rsp_data`=0x88 stable, `req_ready`=0 throughout.
  - Without `ALU_SEQ_B2B_EN`: second request accepted 1 cycle after the response handshake.
  - With `ALU_SEQ_B2B_EN`: second request accepted in the same cycle as the handshake.
- SLL a=0x01 shamt=7, assert `rst` on the 3rd SHIFT cycle → `rsp_valid` stays 0, outputs 0, `req_ready` returns 1 after release. Then ADD 0x01+0x01 → 0x02.
